xor_gate: RTL and testbench

//   Bitwise two-input exclusive-OR with a registered output stage.

---
 rtl/xor_gate_pkg.sv | 7 +
 rtl/xor_gate.sv | 59 +++++
 tb/tb_xor_gate.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/xor_gate_pkg.sv
// Shared defaults for the clocked XOR leaf primitive.
package xor_gate_pkg;

  localparam int unsigned XOR_DEFAULT_WIDTH      = 1;
  localparam bit          XOR_DEFAULT_REGISTERED = 1'b1;

endpackage : xor_gate_pkg

// File: rtl/xor_gate.sv
// Bitwise A ^ B with optional one-cycle register stage, valid flag and result parity.
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int unsigned WIDTH      = XOR_DEFAULT_WIDTH,
  parameter bit          REGISTERED = XOR_DEFAULT_REGISTERED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             out_valid,
  output logic             parity
);

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] f_q;
      logic [WIDTH-1:0] f_d;
      logic             valid_q;
      logic             valid_d;

      // F holds across unqualified cycles; out_valid is a one-cycle pulse per result.
      always_comb begin
        f_d     = f_q;
        valid_d = 1'b0;
        if (in_valid) begin
          f_d     = A ^ B;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          f_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          f_q     <= f_d;
          valid_q <= valid_d;
        end
      end

      assign F         = f_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign F         = A ^ B;
      assign out_valid = in_valid;

      // Stateless variant: clock and reset are deliberately left unconnected.
      logic unused_ok;
      assign unused_ok = clk ^ rst;
    end
  endgenerate

  assign parity = ^F;

endmodule : xor_gate

// File: tb/tb_xor_gate.sv
// Directed-vector bench for xor_gate: registered 1-bit and 8-bit instances plus a bypass instance.
module tb_xor_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic [0:0] f1;
  logic       ov1;
  logic       p1;

  logic       v8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [7:0] f8;
  logic       ov8;
  logic       p8;

  logic       vc = 1'b0;
  logic [0:0] ac = '0;
  logic [0:0] bc = '0;
  logic [0:0] fc;
  logic       ovc;
  logic       pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1),
    .F(f1), .out_valid(ov1), .parity(p1)
  );

  xor_gate #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8),
    .F(f8), .out_valid(ov8), .parity(p8)
  );

  xor_gate #(.WIDTH(1), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst(rst), .in_valid(vc), .A(ac), .B(bc),
    .F(fc), .out_valid(ovc), .parity(pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-bit vectors {A,B} and their hand-computed XOR results.
  logic [1:0] vec_ab  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic       vec_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset for two cycles, then check the cleared state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_w1_f",   32'(f1),  32'h0);
    check("rst_w1_ov",  32'(ov1), 32'h0);
    check("rst_w1_par", 32'(p1),  32'h0);
    check("rst_w8_f",   32'(f8),  32'h0);
    check("rst_w8_ov",  32'(ov8), 32'h0);
    check("rst_w8_par", 32'(p8),  32'h0);

    // 1-bit truth table, one cycle of latency.
    for (int i = 0; i < 5; i++) begin
      a1 = vec_ab[i][1];
      b1 = vec_ab[i][0];
      v1 = 1'b1;
      step();
      check($sformatf("tt_f[%0d]", i),   32'(f1),  32'(vec_exp[i]));
      check($sformatf("tt_ov[%0d]", i),  32'(ov1), 32'h1);
      check($sformatf("tt_par[%0d]", i), 32'(p1),  32'(vec_exp[i]));
    end

    // 8-bit operation and parity.
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    step();
    check("w8_f_cc",   32'(f8),  32'hCC);
    check("w8_par_cc", 32'(p8),  32'h0);
    check("w8_ov_cc",  32'(ov8), 32'h1);

    // Unqualified inputs: F holds, out_valid drops.
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(8'h11 * (i + 1));
      b8 = 8'(8'h5A + i);
      step();
      check($sformatf("hold_f[%0d]", i),  32'(f8),  32'hCC);
      check($sformatf("hold_ov[%0d]", i), 32'(ov8), 32'h0);
    end

    a8 = 8'h01; b8 = 8'h00; v8 = 1'b1;
    step();
    check("w8_f_01",   32'(f8),  32'h01);
    check("w8_par_01", 32'(p8),  32'h1);
    check("w8_ov_01",  32'(ov8), 32'h1);
    v8 = 1'b0;

    // Reset wins over in_valid and discards the in-flight result.
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    step();
    check("pre_rst_f", 32'(f1), 32'h1);
    rst = 1'b1;
    step();
    check("rst_pri_f",   32'(f1),  32'h0);
    check("rst_pri_ov",  32'(ov1), 32'h0);
    check("rst_pri_par", 32'(p1),  32'h0);
    check("rst_w8_f2",   32'(f8),  32'h0);
    rst = 1'b0;
    v1 = 1'b0;
    step();
    check("post_rst_ov", 32'(ov1), 32'h0);

    // Bypass instance tracks inputs without any clock edge.
    for (int i = 0; i < 4; i++) begin
      ac = vec_ab[i][1];
      bc = vec_ab[i][0];
      vc = (i % 2 == 1);
      #1;
      check($sformatf("comb_f[%0d]", i),   32'(fc),  32'(vec_exp[i]));
      check($sformatf("comb_par[%0d]", i), 32'(pc),  32'(vec_exp[i]));
      check($sformatf("comb_ov[%0d]", i),  32'(ovc), 32'(i % 2 == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xor_gate
